// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | if_fetch_unit : instruction fetch with prefetch FIFO and IF/ID register    |
// | Optional bubble counter when IF_PERF_CNT_EN is defined.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module if_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INST_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       if_bubble_cnt,
`endif
  output logic              if_valid
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_run;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   r_stale_addr;
  logic [ADDR_W-1:0]   r_fifo_pc   [DEPTH];
  logic [INST_W-1:0]   r_fifo_inst [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0]   r_if_pc;
  logic [INST_W-1:0]   r_if_inst;
  logic                r_if_valid;

  logic w_req;
  logic w_ack;
  logic w_fifo_empty;
  logic w_fetch_ack;
  logic w_pop;
  logic w_bypass;
  logic w_push;

  // Request and address come from registers only; r_run keeps req low in the reset cycle.
  assign w_req        = r_run & ((r_state == ST_DISCARD) | (r_count != c_DEPTH));
  assign imem_req_o   = w_req;
  assign imem_addr_o  = (r_state == ST_DISCARD) ? r_stale_addr : r_fetch_pc;
  assign w_ack        = w_req & imem_ack_i;
  assign w_fifo_empty = (r_count == '0);
  assign w_fetch_ack  = w_ack & (r_state == ST_FETCH) & ~flush_i;
  assign w_pop        = ~flush_i & ~stall_i & ~w_fifo_empty;
  assign w_bypass     = ~flush_i & ~stall_i & w_fifo_empty & w_fetch_ack;
  assign w_push       = w_fetch_ack & ~w_bypass;

  assign if_pc    = r_if_pc;
  assign if_inst  = r_if_inst;
  assign if_valid = r_if_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:   if (flush_i && w_req && !imem_ack_i) w_state_nxt = ST_DISCARD;
      ST_DISCARD: if (imem_ack_i) w_state_nxt = ST_FETCH;
      default:    w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run        <= 1'b0;
      r_fetch_pc   <= RESET_PC;
      r_stale_addr <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_if_pc      <= '0;
      r_if_inst    <= '0;
      r_if_valid   <= 1'b0;
    end else begin
      r_run <= 1'b1;

      if (flush_i) begin
        r_fetch_pc <= redirect_pc_i;
        // Only a fresh in-flight request captures the stale address; DISCARD keeps its own.
        if (r_state == ST_FETCH && w_req && !imem_ack_i)
          r_stale_addr <= r_fetch_pc;
      end else if (w_fetch_ack) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end

      if (flush_i) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end

      if (flush_i) begin
        r_if_inst  <= '0;
        r_if_valid <= 1'b0;
      end else if (!stall_i) begin
        if (!w_fifo_empty) begin
          r_if_pc    <= r_fifo_pc[r_rd_ptr];
          r_if_inst  <= r_fifo_inst[r_rd_ptr];
          r_if_valid <= 1'b1;
        end else if (w_bypass) begin
          r_if_pc    <= imem_addr_o;
          r_if_inst  <= imem_rdata_i;
          r_if_valid <= 1'b1;
        end else begin
          r_if_inst  <= '0;
          r_if_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= imem_addr_o;
      r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        w_bubble;
  logic [31:0] r_bubble_cnt;

  assign w_bubble      = ~stall_i & ~flush_i & w_fifo_empty & ~w_bypass;
  assign if_bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end
`else
  // Bubble counter not built.
`endif

endmodule
`default_nettype wire
